// File: rtl/dispatcher_pkg.sv
// Shared types and width helpers for the dispatcher resource-table front-end.
package dispatcher_pkg;

    localparam int RES_ID_WIDTH_DFLT = 4;
    localparam int RES_SIZE_WIDTH    = RES_ID_WIDTH_DFLT + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_REPORT
    } seq_state_t;

    typedef enum logic {
        SRV_ALLOC,
        SRV_DEALLOC
    } srv_side_t;

    function automatic int res_size_width(input int id_width);
        return id_width + 1;
    endfunction

endpackage

// File: rtl/dealloc_req_fifo.sv
// Small synchronous FIFO of pending dealloc requests ({cu_id, wg_slot_id}).
module dealloc_req_fifo #(
    parameter int DW    = 5,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_data  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/res_table_cmd_sequencer.sv
// Serialises alloc/dealloc commands to the resource table and forwards the
// table's biggest-free-space result to the allocator CAM.
module res_table_cmd_sequencer
    import dispatcher_pkg::*;
#(
    parameter int CU_ID_WIDTH        = 1,
    parameter int NUMBER_CU          = 2,
    parameter int WG_SLOT_ID_WIDTH   = 4,
    parameter int RES_ID_WIDTH       = RES_ID_WIDTH_DFLT,
    parameter int NUMBER_RES_SLOTS   = 16,
    parameter int DEALLOC_FIFO_DEPTH = 4,
    localparam int SZW               = res_size_width(RES_ID_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_req_valid,
    output logic                        alloc_req_ready,
    input  logic [CU_ID_WIDTH-1:0]      alloc_req_cu_id,
    input  logic [WG_SLOT_ID_WIDTH-1:0] alloc_req_wg_slot_id,
    input  logic [RES_ID_WIDTH-1:0]     alloc_req_res_start,
    input  logic [SZW-1:0]              alloc_req_res_size,
    input  logic                        dealloc_req_valid,
    output logic                        dealloc_req_ready,
    input  logic [CU_ID_WIDTH-1:0]      dealloc_req_cu_id,
    input  logic [WG_SLOT_ID_WIDTH-1:0] dealloc_req_wg_slot_id,
    output logic                        alloc_res_en,
    output logic                        dealloc_res_en,
    output logic [CU_ID_WIDTH-1:0]      alloc_cu_id,
    output logic [WG_SLOT_ID_WIDTH-1:0] alloc_wg_slot_id,
    output logic [RES_ID_WIDTH-1:0]     alloc_res_start,
    output logic [SZW-1:0]              alloc_res_size,
    output logic [CU_ID_WIDTH-1:0]      dealloc_cu_id,
    output logic [WG_SLOT_ID_WIDTH-1:0] dealloc_wg_slot_id,
    input  logic                        res_table_done,
    input  logic [SZW-1:0]              cam_biggest_space_size,
    input  logic [RES_ID_WIDTH-1:0]     cam_biggest_space_addr,
    output logic                        cam_up_valid,
    output logic [CU_ID_WIDTH-1:0]      cam_up_cu_id,
    output logic [SZW-1:0]              cam_up_size,
    output logic [RES_ID_WIDTH-1:0]     cam_up_addr,
    output logic                        busy,
    output logic                        err_spurious_done
);
    localparam int DW = CU_ID_WIDTH + WG_SLOT_ID_WIDTH;

    if ((NUMBER_CU > (1 << CU_ID_WIDTH)) ||
        (NUMBER_RES_SLOTS > (1 << RES_ID_WIDTH))) begin : g_cfg_bad
        $error("CU or resource-slot count exceeds its id width");
    end

    seq_state_t                r_state;
    srv_side_t                 r_last;
    logic [CU_ID_WIDTH-1:0]    r_cu;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_sel_alloc;
    logic                      w_sel_dealloc;
    logic [DW-1:0]             w_head;
    logic [CU_ID_WIDTH-1:0]    w_head_cu;
    logic [WG_SLOT_ID_WIDTH-1:0] w_head_wg;

    dealloc_req_fifo #(
        .DW    (DW),
        .DEPTH (DEALLOC_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (dealloc_req_valid),
        .i_data  ({dealloc_req_cu_id, dealloc_req_wg_slot_id}),
        .i_pop   (w_sel_dealloc),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_cu = w_head[DW-1:WG_SLOT_ID_WIDTH];
    assign w_head_wg = w_head[WG_SLOT_ID_WIDTH-1:0];

    // With both sides pending, serve whichever side was not served last.
    assign w_sel_alloc   = (r_state == ST_IDLE) && alloc_req_valid &&
                           (w_empty || (r_last == SRV_DEALLOC));
    assign w_sel_dealloc = (r_state == ST_IDLE) && !w_empty &&
                           (!alloc_req_valid || (r_last == SRV_ALLOC));

    assign alloc_req_ready   = w_sel_alloc;
    assign dealloc_req_ready = !w_full;
    assign busy              = (r_state != ST_IDLE) || !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= ST_IDLE;
            r_last             <= SRV_ALLOC;
            r_cu               <= '0;
            alloc_res_en       <= 1'b0;
            dealloc_res_en     <= 1'b0;
            alloc_cu_id        <= '0;
            alloc_wg_slot_id   <= '0;
            alloc_res_start    <= '0;
            alloc_res_size     <= '0;
            dealloc_cu_id      <= '0;
            dealloc_wg_slot_id <= '0;
            cam_up_valid       <= 1'b0;
            cam_up_cu_id       <= '0;
            cam_up_size        <= '0;
            cam_up_addr        <= '0;
            err_spurious_done  <= 1'b0;
        end else begin
            alloc_res_en   <= 1'b0;
            dealloc_res_en <= 1'b0;
            cam_up_valid   <= 1'b0;
            if (res_table_done && (r_state != ST_WAIT_DONE)) begin
                err_spurious_done <= 1'b1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_sel_alloc) begin
                        r_state          <= ST_ISSUE;
                        r_last           <= SRV_ALLOC;
                        r_cu             <= alloc_req_cu_id;
                        alloc_res_en     <= 1'b1;
                        alloc_cu_id      <= alloc_req_cu_id;
                        alloc_wg_slot_id <= alloc_req_wg_slot_id;
                        alloc_res_start  <= alloc_req_res_start;
                        alloc_res_size   <= alloc_req_res_size;
                    end else if (w_sel_dealloc) begin
                        r_state            <= ST_ISSUE;
                        r_last             <= SRV_DEALLOC;
                        r_cu               <= w_head_cu;
                        dealloc_res_en     <= 1'b1;
                        dealloc_cu_id      <= w_head_cu;
                        dealloc_wg_slot_id <= w_head_wg;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (res_table_done) begin
                        r_state      <= ST_REPORT;
                        cam_up_valid <= 1'b1;
                        cam_up_cu_id <= r_cu;
                        cam_up_size  <= cam_biggest_space_size;
                        cam_up_addr  <= cam_biggest_space_addr;
                    end
                end
                ST_REPORT: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_res_table_cmd_sequencer.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run against a timestamp-based reference model.
module tb_res_table_cmd_sequencer;
    localparam int CUW   = 1;
    localparam int WGW   = 4;
    localparam int RIW   = 4;
    localparam int SZW   = 5;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           alloc_req_valid;
    logic           alloc_req_ready;
    logic [CUW-1:0] alloc_req_cu_id;
    logic [WGW-1:0] alloc_req_wg_slot_id;
    logic [RIW-1:0] alloc_req_res_start;
    logic [SZW-1:0] alloc_req_res_size;
    logic           dealloc_req_valid;
    logic           dealloc_req_ready;
    logic [CUW-1:0] dealloc_req_cu_id;
    logic [WGW-1:0] dealloc_req_wg_slot_id;
    logic           alloc_res_en;
    logic           dealloc_res_en;
    logic [CUW-1:0] alloc_cu_id;
    logic [WGW-1:0] alloc_wg_slot_id;
    logic [RIW-1:0] alloc_res_start;
    logic [SZW-1:0] alloc_res_size;
    logic [CUW-1:0] dealloc_cu_id;
    logic [WGW-1:0] dealloc_wg_slot_id;
    logic           res_table_done;
    logic [SZW-1:0] cam_biggest_space_size;
    logic [RIW-1:0] cam_biggest_space_addr;
    logic           cam_up_valid;
    logic [CUW-1:0] cam_up_cu_id;
    logic [SZW-1:0] cam_up_size;
    logic [RIW-1:0] cam_up_addr;
    logic           busy;
    logic           err_spurious_done;

    res_table_cmd_sequencer dut (
        .clk                    (clk),
        .rst                    (rst),
        .alloc_req_valid        (alloc_req_valid),
        .alloc_req_ready        (alloc_req_ready),
        .alloc_req_cu_id        (alloc_req_cu_id),
        .alloc_req_wg_slot_id   (alloc_req_wg_slot_id),
        .alloc_req_res_start    (alloc_req_res_start),
        .alloc_req_res_size     (alloc_req_res_size),
        .dealloc_req_valid      (dealloc_req_valid),
        .dealloc_req_ready      (dealloc_req_ready),
        .dealloc_req_cu_id      (dealloc_req_cu_id),
        .dealloc_req_wg_slot_id (dealloc_req_wg_slot_id),
        .alloc_res_en           (alloc_res_en),
        .dealloc_res_en         (dealloc_res_en),
        .alloc_cu_id            (alloc_cu_id),
        .alloc_wg_slot_id       (alloc_wg_slot_id),
        .alloc_res_start        (alloc_res_start),
        .alloc_res_size         (alloc_res_size),
        .dealloc_cu_id          (dealloc_cu_id),
        .dealloc_wg_slot_id     (dealloc_wg_slot_id),
        .res_table_done         (res_table_done),
        .cam_biggest_space_size (cam_biggest_space_size),
        .cam_biggest_space_addr (cam_biggest_space_addr),
        .cam_up_valid           (cam_up_valid),
        .cam_up_cu_id           (cam_up_cu_id),
        .cam_up_size            (cam_up_size),
        .cam_up_addr            (cam_up_addr),
        .busy                   (busy),
        .err_spurious_done      (err_spurious_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({alloc_req_ready, dealloc_req_ready, alloc_res_en,
                    dealloc_res_en, alloc_cu_id, alloc_wg_slot_id,
                    alloc_res_start, alloc_res_size, dealloc_cu_id,
                    dealloc_wg_slot_id, cam_up_valid, cam_up_cu_id,
                    cam_up_size, cam_up_addr, busy, err_spurious_done});
    endfunction

    task automatic idle_inputs();
        alloc_req_valid        = 1'b0;
        alloc_req_cu_id        = '0;
        alloc_req_wg_slot_id   = '0;
        alloc_req_res_start    = '0;
        alloc_req_res_size     = '0;
        dealloc_req_valid      = 1'b0;
        dealloc_req_cu_id      = '0;
        dealloc_req_wg_slot_id = '0;
        res_table_done         = 1'b0;
        cam_biggest_space_size = '0;
        cam_biggest_space_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_alloc(input string nm, input logic [CUW-1:0] cu,
                             input logic [WGW-1:0] wg, input logic [RIW-1:0] st,
                             input logic [SZW-1:0] sz);
        check({nm, "_cu"}, alloc_cu_id, cu);
        check({nm, "_wg"}, alloc_wg_slot_id, wg);
        check({nm, "_start"}, alloc_res_start, st);
        check({nm, "_size"}, alloc_res_size, sz);
    endtask

    // Waits (bounded) for the next enable pulse and checks its kind and fields.
    task automatic wait_issue(input string nm, input bit exp_alloc,
                              input logic [CUW-1:0] cu, input logic [WGW-1:0] wg);
        int n = 0;
        while (!(alloc_res_en || dealloc_res_en) && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({nm, "_seen"}, alloc_res_en | dealloc_res_en, 1);
        check({nm, "_kind"}, alloc_res_en, exp_alloc);
        check({nm, "_cu"}, exp_alloc ? alloc_cu_id : dealloc_cu_id, cu);
        check({nm, "_wg"}, exp_alloc ? alloc_wg_slot_id : dealloc_wg_slot_id, wg);
    endtask

    // Called during a WAIT_DONE cycle: returns one done pulse, ends in IDLE.
    task automatic finish_cmd(input string nm);
        res_table_done         = 1'b1;
        cam_biggest_space_size = SZW'($urandom);
        cam_biggest_space_addr = RIW'($urandom);
        @(negedge clk);
        res_table_done = 1'b0;
        #1;
        check({nm, "_cam"}, cam_up_valid, 1);
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [CUW-1:0] cu;
        logic [WGW-1:0] wg;
        logic [RIW-1:0] st;
        logic [SZW-1:0] sz;
        int             delay;
        logic [SZW-1:0] bsz;
        logic [RIW-1:0] badr;
        logic [CUW-1:0] e_cu;
        logic [SZW-1:0] e_sz;
        logic [RIW-1:0] e_adr;
    } vec_t;

    vec_t tbl[4];

    typedef struct packed {
        logic [CUW-1:0] cu;
        logic [WGW-1:0] wg;
    } dq_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp_rst;
        dq_t mq[$];
        dq_t hd;
        int  e_now, t_acc, d_edge;
        bit  last_alloc, m_err, c_alloc, act, wt, sa, sd, push;
        logic [CUW-1:0] c_cu;
        logic [WGW-1:0] c_wg;
        logic [RIW-1:0] c_st, m_badr;
        logic [SZW-1:0] c_sz, m_bsz;

        tbl[0] = '{0, 0, 0, 5, 0, 11, 5, 0, 11, 5};
        tbl[1] = '{1, 9, 3, 2, 1, 16, 0, 1, 16, 0};
        tbl[2] = '{0, 15, 15, 16, 10, 0, 15, 0, 0, 15};
        tbl[3] = '{1, 4, 8, 1, 2, 7, 9, 1, 7, 9};
        exp_rst     = '0;
        exp_rst[34] = 1'b1;

        do_reset();
        #1;
        check("reset_outs", outs(), exp_rst);

        // Directed single-alloc vectors, including a 10-cycle done stall.
        for (int v = 0; v < 4; v++) begin
            alloc_req_valid      = 1'b1;
            alloc_req_cu_id      = tbl[v].cu;
            alloc_req_wg_slot_id = tbl[v].wg;
            alloc_req_res_start  = tbl[v].st;
            alloc_req_res_size   = tbl[v].sz;
            #1;
            check("t_ready", alloc_req_ready, 1);
            @(negedge clk);
            alloc_req_cu_id      = ~tbl[v].cu;
            alloc_req_wg_slot_id = ~tbl[v].wg;
            alloc_req_res_start  = ~tbl[v].st;
            alloc_req_res_size   = ~tbl[v].sz;
            #1;
            check("t_en", alloc_res_en, 1);
            check("t_den", dealloc_res_en, 0);
            check("t_busy", busy, 1);
            chk_alloc("t_issue", tbl[v].cu, tbl[v].wg, tbl[v].st, tbl[v].sz);
            for (int d = 0; d < tbl[v].delay; d++) begin
                @(negedge clk);
                #1;
                check("t_wait_en", alloc_res_en, 0);
                check("t_wait_rdy", alloc_req_ready, 0);
                check("t_wait_busy", busy, 1);
                chk_alloc("t_wait", tbl[v].cu, tbl[v].wg, tbl[v].st, tbl[v].sz);
            end
            @(negedge clk);
            alloc_req_valid        = 1'b0;
            res_table_done         = 1'b1;
            cam_biggest_space_size = tbl[v].bsz;
            cam_biggest_space_addr = tbl[v].badr;
            #1;
            check("t_pre_cam", cam_up_valid, 0);
            @(negedge clk);
            res_table_done         = 1'b0;
            cam_biggest_space_size = ~tbl[v].bsz;
            cam_biggest_space_addr = ~tbl[v].badr;
            #1;
            check("t_cam_valid", cam_up_valid, 1);
            check("t_cam_cu", cam_up_cu_id, tbl[v].e_cu);
            check("t_cam_size", cam_up_size, tbl[v].e_sz);
            check("t_cam_addr", cam_up_addr, tbl[v].e_adr);
            chk_alloc("t_report", tbl[v].cu, tbl[v].wg, tbl[v].st, tbl[v].sz);
            @(negedge clk);
            #1;
            check("t_cam_drop", cam_up_valid, 0);
            check("t_idle_busy", busy, 0);
        end

        // Spurious done while idle.
        check("spur_pre", err_spurious_done, 0);
        res_table_done = 1'b1;
        @(negedge clk);
        res_table_done = 1'b0;
        #1;
        check("spur_err", err_spurious_done, 1);
        check("spur_cam", cam_up_valid, 0);
        check("spur_busy", busy, 0);
        repeat (3) @(negedge clk);
        #1;
        check("spur_sticky", err_spurious_done, 1);
        alloc_req_valid = 1'b1;
        #1;
        check("spur_idle", alloc_req_ready, 1);
        alloc_req_valid = 1'b0;

        // FIFO fills while the table stalls; the fifth waits for a pop.
        @(negedge clk);
        alloc_req_valid      = 1'b1;
        alloc_req_cu_id      = 1;
        alloc_req_wg_slot_id = 3;
        @(negedge clk);
        alloc_req_valid = 1'b0;
        #1;
        check("fifo_alloc_en", alloc_res_en, 1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            dealloc_req_valid      = 1'b1;
            dealloc_req_cu_id      = CUW'(i);
            dealloc_req_wg_slot_id = WGW'(i);
            #1;
            check("fifo_rdy", dealloc_req_ready, i < 4);
            @(negedge clk);
        end
        #1;
        check("fifo_full_rdy", dealloc_req_ready, 0);
        res_table_done = 1'b1;
        @(negedge clk);
        res_table_done = 1'b0;
        #1;
        check("fifo_cam", cam_up_valid, 1);
        check("fifo_rpt_rdy", dealloc_req_ready, 0);
        @(negedge clk);
        #1;
        check("fifo_idle_rdy", dealloc_req_ready, 0);
        @(negedge clk);
        #1;
        check("fifo_pop_rdy", dealloc_req_ready, 1);
        check("fifo_d0_en", dealloc_res_en, 1);
        check("fifo_d0_cu", dealloc_cu_id, 0);
        check("fifo_d0_wg", dealloc_wg_slot_id, 0);
        @(negedge clk);
        dealloc_req_valid = 1'b0;
        finish_cmd("fifo_d0");
        for (int k = 1; k < 5; k++) begin
            wait_issue("fifo_dk", 1'b0, CUW'(k), WGW'(k));
            @(negedge clk);
            finish_cmd("fifo_dk");
        end
        check("fifo_drained", busy, 0);

        // Asynchronous reset during WAIT_DONE with two queued deallocs.
        alloc_req_valid      = 1'b1;
        alloc_req_cu_id      = 0;
        alloc_req_wg_slot_id = 5;
        @(negedge clk);
        alloc_req_valid = 1'b0;
        @(negedge clk);
        dealloc_req_valid      = 1'b1;
        dealloc_req_cu_id      = 1;
        dealloc_req_wg_slot_id = 9;
        @(negedge clk);
        dealloc_req_wg_slot_id = 10;
        @(negedge clk);
        dealloc_req_valid = 1'b0;
        #1;
        check("rst_pre_busy", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_outs_async", outs(), exp_rst);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_post_cam", cam_up_valid, 0);
            check("rst_post_busy", busy, 0);
        end

        // Alternation with last_served=ALLOC after reset.
        dealloc_req_valid      = 1'b1;
        dealloc_req_cu_id      = 1;
        dealloc_req_wg_slot_id = 2;
        @(negedge clk);
        dealloc_req_cu_id      = 0;
        dealloc_req_wg_slot_id = 3;
        alloc_req_valid        = 1'b1;
        alloc_req_cu_id        = 1;
        alloc_req_wg_slot_id   = 7;
        #1;
        check("ord_ardy", alloc_req_ready, 0);
        @(negedge clk);
        dealloc_req_valid = 1'b0;
        #1;
        wait_issue("ord1", 1'b0, 1, 2);
        @(negedge clk);
        finish_cmd("ord1");
        wait_issue("ord2", 1'b1, 1, 7);
        alloc_req_valid = 1'b0;
        @(negedge clk);
        finish_cmd("ord2");
        wait_issue("ord3", 1'b0, 0, 3);
        @(negedge clk);
        finish_cmd("ord3");
        check("ord_idle", busy, 0);

        // Randomized run against a timestamp-based model.
        do_reset();
        mq.delete();
        e_now      = 0;
        t_acc      = -1;
        d_edge     = -1;
        last_alloc = 1'b1;
        m_err      = 1'b0;
        c_alloc    = 1'b0;
        c_cu = '0; c_wg = '0; c_st = '0; c_sz = '0;
        m_bsz = '0; m_badr = '0;
        for (int i = 0; i < 1500; i++) begin
            act = (t_acc >= 0) && !((d_edge >= 0) && (e_now > d_edge));
            wt  = act && (e_now > t_acc) && (d_edge < 0);
            alloc_req_valid        = ($urandom_range(0, 2) != 0);
            alloc_req_cu_id        = CUW'($urandom);
            alloc_req_wg_slot_id   = WGW'($urandom);
            alloc_req_res_start    = RIW'($urandom);
            alloc_req_res_size     = SZW'($urandom);
            dealloc_req_valid      = ($urandom_range(0, 3) == 0);
            dealloc_req_cu_id      = CUW'($urandom);
            dealloc_req_wg_slot_id = WGW'($urandom);
            res_table_done = wt ? ($urandom_range(0, 2) == 0)
                                : ($urandom_range(0, 199) == 0);
            cam_biggest_space_size = SZW'($urandom);
            cam_biggest_space_addr = RIW'($urandom);
            #1;
            sa = !act && alloc_req_valid && (mq.size() == 0 || !last_alloc);
            sd = !act && (mq.size() != 0) && !sa;
            check("r_ardy", alloc_req_ready, sa);
            check("r_drdy", dealloc_req_ready, mq.size() < DEPTH);
            check("r_busy", busy, act || (mq.size() != 0));
            check("r_aen", alloc_res_en, act && (e_now == t_acc) && c_alloc);
            check("r_den", dealloc_res_en, act && (e_now == t_acc) && !c_alloc);
            check("r_cam", cam_up_valid, act && (e_now == d_edge));
            check("r_err", err_spurious_done, m_err);
            if (act && c_alloc) chk_alloc("r_afld", c_cu, c_wg, c_st, c_sz);
            if (act && !c_alloc) begin
                check("r_dcu", dealloc_cu_id, c_cu);
                check("r_dwg", dealloc_wg_slot_id, c_wg);
            end
            if (act && (e_now == d_edge)) begin
                check("r_cam_cu", cam_up_cu_id, c_cu);
                check("r_cam_sz", cam_up_size, m_bsz);
                check("r_cam_ad", cam_up_addr, m_badr);
            end
            push = dealloc_req_valid && (mq.size() < DEPTH);
            if (sa || sd) begin
                t_acc      = e_now + 1;
                d_edge     = -1;
                c_alloc    = sa;
                last_alloc = sa;
                if (sa) begin
                    c_cu = alloc_req_cu_id;
                    c_wg = alloc_req_wg_slot_id;
                    c_st = alloc_req_res_start;
                    c_sz = alloc_req_res_size;
                end else begin
                    hd   = mq.pop_front();
                    c_cu = hd.cu;
                    c_wg = hd.wg;
                end
            end else if (wt && res_table_done) begin
                d_edge = e_now + 1;
                m_bsz  = cam_biggest_space_size;
                m_badr = cam_biggest_space_addr;
            end
            if (res_table_done && !wt) m_err = 1'b1;
            if (push) mq.push_back('{dealloc_req_cu_id, dealloc_req_wg_slot_id});
            e_now++;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/res_table_cmd_sequencer.md
# res_table_cmd_sequencer

Front-end sequencer for the dispatcher's `resource_table`. It accepts workgroup allocation requests from the allocator and deallocation requests from workgroup completion, and buffers deallocations in a small FIFO. It issues exactly one single-cycle command at a time to the resource table and waits for `res_table_done`. It then captures the table's biggest-free-space result and forwards it, tagged with the CU id, as a one-cycle update to the allocator's per-CU CAM.

## Interface
- CU_ID_WIDTH, 1, CU id width
- NUMBER_CU, 2, number of CUs
- WG_SLOT_ID_WIDTH, 4, WG slot id width
- RES_ID_WIDTH, 4, resource address width; sizes are RES_ID_WIDTH+1 bits
- NUMBER_RES_SLOTS, 16, resource slots per CU
- DEALLOC_FIFO_DEPTH, 4, dealloc queue entries (power of two)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- alloc_req_valid  in  1  alloc request present
- alloc_req_ready  out  1  alloc request accepted this cycle when valid&ready
- alloc_req_cu_id / alloc_req_wg_slot_id  in  CU_ID_WIDTH / WG_SLOT_ID_WIDTH  target
- alloc_req_res_start  in  RES_ID_WIDTH  first slot
- alloc_req_res_size  in  RES_ID_WIDTH+1  slot count
- dealloc_req_valid  in  1  dealloc request present
- dealloc_req_ready  out  1  FIFO not full
- dealloc_req_cu_id / dealloc_req_wg_slot_id  in  CU_ID_WIDTH / WG_SLOT_ID_WIDTH  target
- alloc_res_en, dealloc_res_en  out  1  command pulses to the table
- alloc_cu_id, alloc_wg_slot_id, alloc_res_start, alloc_res_size  out  matching widths  alloc command fields
- dealloc_cu_id, dealloc_wg_slot_id  out  matching widths  dealloc command fields
- res_table_done  in  1  table finished current command (pulse)
- cam_biggest_space_size  in  RES_ID_WIDTH+1  from the table
- cam_biggest_space_addr  in  RES_ID_WIDTH  from the table
- cam_up_valid  out  1  one-cycle CAM update strobe
- cam_up_cu_id / cam_up_size / cam_up_addr  out  CU_ID_WIDTH / RES_ID_WIDTH+1 / RES_ID_WIDTH  update payload
- busy  out  1  state != IDLE or FIFO non-empty
- err_spurious_done  out  1  sticky; set by res_table_done outside WAIT_DONE

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, REPORT. Reset enters IDLE.
- Reset values: all outputs 0 except dealloc_req_ready=1. FIFO is empty. last_served=ALLOC.
- Dealloc FIFO:
  - Pushes on dealloc_req_valid & dealloc_req_ready in any state.
  - dealloc_req_ready = !full. There is no same-cycle pass-through when full.
- Arbitration in IDLE:
  - Only one side pending: that side is served.
  - Both pending: serve the side not equal to last_served (alternate), then update last_served.
- alloc_req_ready is 1 only in IDLE when arbitration selects alloc.
- Dealloc service pops the FIFO head in the same cycle.
- The chosen command and CU id are latched into registers on the selection edge.
- ISSUE lasts exactly 1 cycle:
  - The selected alloc_res_en or dealloc_res_en is high and the other is 0.
  - Command fields are held stable from ISSUE until the FSM leaves REPORT.
- WAIT_DONE: hold until res_table_done=1. On that edge, capture cam_biggest_space_size/addr and go to REPORT.
- REPORT lasts 1 cycle. cam_up_valid=1 with the latched CU id and captured size/addr. Then go to IDLE.
- res_table_done in IDLE, ISSUE or REPORT is ignored by the FSM and sets err_spurious_done. Only reset clears it.
- Reset mid-operation: the FSM returns to IDLE, the FIFO is flushed, and pulses drop immediately (asynchronous). The in-flight command is dropped with no report.

## Timing
- Accept at edge N → enable pulse in cycle N+1.
- If done is sampled at edge M (M ≥ N+2), cam_up_valid is high in cycle M+1, and the next command can be accepted at edge M+2.
- Minimum command-to-command spacing is 4 cycles, assuming done returns in the first WAIT_DONE cycle.
- Dealloc push-to-pop latency when idle with the FIFO empty is 1 edge.
- Simultaneous FIFO push and pop in the same cycle leaves the count unchanged.

## Structure
- Shared package `dispatcher_pkg` holds:
  - FSM state encoding.
  - The ALLOC/DEALLOC arbitration enum.
  - Width-derived constants (RES_SIZE_WIDTH = RES_ID_WIDTH+1).
- One sub-module, `dealloc_req_fifo`: synchronous FIFO of {cu_id, wg_slot_id}, with full/empty flags and wrap-around pointers using an extra MSB.

## Test plan
- Reset, then alloc (cu0, slot0, start0, size5) → alloc_res_en high exactly 1 cycle with fields 0/0/0/5. Drive done=1 with size 11, addr 5 → cam_up_valid 1 cycle with cu0/11/5.
- alloc pending and 2 deallocs queued, last_served=ALLOC → order dealloc, alloc, dealloc. Each enable pulse is separated by the done handshake.
- 5 back-to-back deallocs while WAIT_DONE is stalled → first 4 accepted. dealloc_req_ready=0 on the 5th until the first pop, then accepted.
- res_table_done pulse in IDLE → err_spurious_done=1 and stays 1, no cam_up_valid, FSM stays IDLE.
- Assert rst during WAIT_DONE with 2 FIFO entries → all outputs at reset values within the same cycle, busy=0 after reset, no cam_up_valid.
- done delayed 10 cycles → command fields stable throughout, busy=1, alloc_req_ready=0.
